// File: rtl/rv_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_mdu_pkg
// Description : Opcodes, FSM state encoding and operand-sign helpers for rv_mdu.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_mdu_pkg;

    localparam int MDU_OP_W = 3;

    localparam logic [MDU_OP_W-1:0] MDU_MUL    = 3'b000;
    localparam logic [MDU_OP_W-1:0] MDU_MULH   = 3'b001;
    localparam logic [MDU_OP_W-1:0] MDU_MULHSU = 3'b010;
    localparam logic [MDU_OP_W-1:0] MDU_MULHU  = 3'b011;
    localparam logic [MDU_OP_W-1:0] MDU_DIV    = 3'b100;
    localparam logic [MDU_OP_W-1:0] MDU_DIVU   = 3'b101;
    localparam logic [MDU_OP_W-1:0] MDU_REM    = 3'b110;
    localparam logic [MDU_OP_W-1:0] MDU_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_t;

    // MUL only uses the low product half, which is sign-invariant.
    function automatic logic op_a_signed(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) ||
               (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    function automatic logic op_b_signed(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_MUL) || (op == MDU_MULH) ||
               (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_mdu_if.sv
`default_nettype none
// ============================================================================
// Module      : rv_mdu_if
// Description : Execute-stage request/result bundle between pipeline and rv_mdu.
// Revision    : 1.0 - initial release
// ============================================================================
interface rv_mdu_if #(
    parameter int XLEN = 32
);
    import rv_mdu_pkg::*;

    logic                mdu_req_i;
    logic [MDU_OP_W-1:0] mdu_op_i;
    logic [XLEN-1:0]     mdu_port_a_i;
    logic [XLEN-1:0]     mdu_port_b_i;
    logic                mdu_kill_i;
    logic                mdu_stall_req_o;
    logic                mdu_done_o;
    logic [XLEN-1:0]     mdu_result_o;

    modport master (
        output mdu_req_i, mdu_op_i, mdu_port_a_i, mdu_port_b_i, mdu_kill_i,
        input  mdu_stall_req_o, mdu_done_o, mdu_result_o
    );

    modport slave (
        input  mdu_req_i, mdu_op_i, mdu_port_a_i, mdu_port_b_i, mdu_kill_i,
        output mdu_stall_req_o, mdu_done_o, mdu_result_o
    );

endinterface
`default_nettype wire

// File: rtl/rv_mdu_div.sv
`default_nettype none
// ============================================================================
// Module      : rv_mdu_div
// Description : Radix-2 restoring divider on unsigned magnitudes, one bit/step.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_mdu_div #(
    parameter int XLEN = 32
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            i_start,
    input  wire logic            i_step,
    input  wire logic [XLEN-1:0] i_dividend,
    input  wire logic [XLEN-1:0] i_divisor,
    output logic      [XLEN-1:0] o_quotient,
    output logic      [XLEN-1:0] o_remainder
);

    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_div;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_neg;

    // Remainder stays below the divisor, so one guard bit holds the shift.
    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_div};
    assign w_neg   = w_diff[XLEN];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_quo <= '0;
            r_rem <= '0;
            r_div <= '0;
        end else if (i_start) begin
            r_quo <= i_dividend;
            r_rem <= '0;
            r_div <= i_divisor;
        end else if (i_step) begin
            r_quo <= {r_quo[XLEN-2:0], ~w_neg};
            r_rem <= w_neg ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule
`default_nettype wire

// File: rtl/rv_mdu.sv
`default_nettype none
// ============================================================================
// Module      : rv_mdu
// Description : Iterative RV32M multiply/divide unit with pipeline stall request.
//               Define MDU_FAST_MUL_EN for a single-cycle multiplier path.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_mdu
    import rv_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    rv_mdu_if.slave   mdu
);

    localparam int         c_CNT_W   = $clog2(XLEN);
    localparam logic [1:0] c_ST_IDLE = IDLE;
    localparam logic [1:0] c_ST_CALC = CALC;
    localparam logic [1:0] c_ST_FIX  = FIX;
    localparam logic [1:0] c_ST_DONE = DONE;

    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [MDU_OP_W-1:0] r_op;
    logic                r_sign_a;
    logic                r_sign_b;
    logic [XLEN-1:0]     r_mag_b;
    logic [XLEN-1:0]     r_mul_hi;
    logic [XLEN-1:0]     r_mul_lo;
    logic [XLEN-1:0]     r_result;

    logic [MDU_OP_W-1:0] w_op;
    logic [XLEN-1:0]     w_a;
    logic [XLEN-1:0]     w_b;
    logic                w_accept;
    logic                w_sa;
    logic                w_sb;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic                w_div_zero;
    logic                w_div_ovf;
    logic                w_fast;
    logic [XLEN-1:0]     w_fast_result;
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_prod;
    logic [2*XLEN-1:0]   w_prod_fix;
    logic                w_mul_neg;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic                w_div_step;
    logic [XLEN-1:0]     w_fix_result;

    assign w_op     = mdu.mdu_op_i;
    assign w_a      = mdu.mdu_port_a_i;
    assign w_b      = mdu.mdu_port_b_i;
    assign w_accept = (r_state == c_ST_IDLE) & mdu.mdu_req_i & ~mdu.mdu_kill_i;

    assign w_sa    = op_a_signed(w_op) & w_a[XLEN-1];
    assign w_sb    = op_b_signed(w_op) & w_b[XLEN-1];
    assign w_mag_a = w_sa ? (-w_a) : w_a;
    assign w_mag_b = w_sb ? (-w_b) : w_b;

    // op[2] marks divide/remainder; op[0]=0 within those marks the signed forms.
    assign w_div_zero = w_op[2] & (w_b == '0);
    assign w_div_ovf  = w_op[2] & ~w_op[0] &
                        (w_a == {1'b1, {(XLEN-1){1'b0}}}) & (w_b == '1);

`ifdef MDU_FAST_MUL_EN
    logic signed [XLEN:0]     w_fast_a;
    logic signed [XLEN:0]     w_fast_b;
    logic signed [2*XLEN+1:0] w_fast_prod;

    assign w_fast_a    = {op_a_signed(w_op) & w_a[XLEN-1], w_a};
    assign w_fast_b    = {op_b_signed(w_op) & w_b[XLEN-1], w_b};
    assign w_fast_prod = w_fast_a * w_fast_b;
`endif

    always_comb begin
        w_fast        = 1'b0;
        w_fast_result = '0;
        if (w_div_zero) begin
            w_fast        = 1'b1;
            w_fast_result = w_op[1] ? w_a : '1;
        end else if (w_div_ovf) begin
            w_fast        = 1'b1;
            w_fast_result = w_op[1] ? '0 : w_a;
        end
`ifdef MDU_FAST_MUL_EN
        else if (!w_op[2]) begin
            w_fast        = 1'b1;
            w_fast_result = (w_op == MDU_MUL) ? w_fast_prod[XLEN-1:0]
                                              : w_fast_prod[2*XLEN-1:XLEN];
        end
`endif
    end

    // Shift-add step: the add carry becomes the new top bit after the shift.
    assign w_mul_sum = {1'b0, r_mul_hi} + (r_mul_lo[0] ? {1'b0, r_mag_b} : '0);

    assign w_prod     = {r_mul_hi, r_mul_lo};
    assign w_mul_neg  = r_sign_a ^ r_sign_b;
    assign w_prod_fix = w_mul_neg ? (-w_prod) : w_prod;

    assign w_div_step = (r_state == c_ST_CALC) & r_op[2];

    rv_mdu_div #(
        .XLEN (XLEN)
    ) u_div (
        .clk         (clk_i),
        .rst         (rst_i),
        .i_start     (w_accept),
        .i_step      (w_div_step),
        .i_dividend  (w_mag_a),
        .i_divisor   (w_mag_b),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    always_comb begin
        w_fix_result = '0;
        case (r_op)
            MDU_MUL:                          w_fix_result = w_prod_fix[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU:  w_fix_result = w_prod_fix[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:                w_fix_result = w_mul_neg ? (-w_quo) : w_quo;
            MDU_REM, MDU_REMU:                w_fix_result = r_sign_a ? (-w_rem) : w_rem;
            default:                          w_fix_result = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_op     <= MDU_MUL;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_mag_b  <= '0;
            r_mul_hi <= '0;
            r_mul_lo <= '0;
            r_result <= '0;
        end else if (mdu.mdu_kill_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (mdu.mdu_req_i) begin
                        r_op     <= w_op;
                        r_sign_a <= w_sa;
                        r_sign_b <= w_sb;
                        r_mag_b  <= w_mag_b;
                        r_mul_hi <= '0;
                        r_mul_lo <= w_mag_a;
                        if (w_fast) begin
                            r_result <= w_fast_result;
                            r_state  <= c_ST_DONE;
                        end else begin
                            r_cnt   <= c_CNT_W'(XLEN - 1);
                            r_state <= c_ST_CALC;
                        end
                    end
                end
                c_ST_CALC: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (!r_op[2]) begin
                        r_mul_hi <= w_mul_sum[XLEN:1];
                        r_mul_lo <= {w_mul_sum[0], r_mul_lo[XLEN-1:1]};
                    end
                    if (r_cnt == '0) begin
                        r_state <= c_ST_FIX;
                    end
                end
                c_ST_FIX: begin
                    r_result <= w_fix_result;
                    r_state  <= c_ST_DONE;
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Stall drops in DONE so the pipeline advances with the valid result.
    assign mdu.mdu_stall_req_o = w_accept | (r_state == c_ST_CALC) | (r_state == c_ST_FIX);
    assign mdu.mdu_done_o      = (r_state == c_ST_DONE) & ~mdu.mdu_kill_i;
    assign mdu.mdu_result_o    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_rv_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_mdu
// Description : Scoreboard testbench for rv_mdu (build with or without MDU_FAST_MUL_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_mdu;
    import rv_mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
    localparam int c_MUL_LAT = 1;
`else
    localparam int c_MUL_LAT = 34;
`endif
    localparam int c_DIV_LAT  = 34;
    localparam int c_FAST_LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rv_mdu_if #(.XLEN(32)) bus ();

    rv_mdu #(
        .XLEN (32)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .mdu   (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_result = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op in an IDLE cycle (cycle 0), scramble inputs after accept,
    // then wait for done and compare result, latency and stall occupancy.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat);
        int cyc       = 0;
        int stall_cnt = 0;
        bit seen      = 1'b0;
        logic [31:0] exp_pop;
        @(negedge clk);
        bus.mdu_req_i    = 1'b1;
        bus.mdu_op_i     = op;
        bus.mdu_port_a_i = a;
        bus.mdu_port_b_i = b;
        sb_q.push_back(exp);
        #1;
        if (bus.mdu_stall_req_o) stall_cnt++;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.mdu_done_o) begin
                seen = 1'b1;
                check({tag, "_stall_at_done"}, 32'(bus.mdu_stall_req_o), 32'd0);
                if (sb_q.size() == 0) begin
                    check({tag, "_sb_empty"}, 32'd1, 32'd0);
                end else begin
                    exp_pop = sb_q.pop_front();
                    check(tag, bus.mdu_result_o, exp_pop);
                end
            end else if (bus.mdu_stall_req_o) begin
                stall_cnt++;
            end
            if (cyc == 1) begin
                bus.mdu_req_i    = 1'b0;
                bus.mdu_op_i     = 3'($urandom);
                bus.mdu_port_a_i = $urandom;
                bus.mdu_port_b_i = $urandom;
            end
        end
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
        check({tag, "_lat"}, 32'(cyc), 32'(lat));
        check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(lat));
        last_result = exp;
    endtask

    initial begin
        int dones;
        bus.mdu_req_i    = 1'b0;
        bus.mdu_op_i     = MDU_MUL;
        bus.mdu_port_a_i = '0;
        bus.mdu_port_b_i = '0;
        bus.mdu_kill_i   = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_stall",  32'(bus.mdu_stall_req_o), 32'd0);
        check("reset_done",   32'(bus.mdu_done_o),      32'd0);
        check("reset_result", bus.mdu_result_o,         32'd0);
        rst = 1'b0;

        run_op("mulh_m2_3",    MDU_MULH,   32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, c_MUL_LAT);
        run_op("div_m7_2",     MDU_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, c_DIV_LAT);
        run_op("rem_m7_2",     MDU_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, c_DIV_LAT);
        run_op("remu_7_2",     MDU_REMU,   32'h0000_0007, 32'h0000_0002, 32'h0000_0001, c_DIV_LAT);
        run_op("divu_by0",     MDU_DIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, c_FAST_LAT);
        run_op("remu_by0",     MDU_REMU,   32'h0000_0009, 32'h0000_0000, 32'h0000_0009, c_FAST_LAT);
        run_op("rem_ovf",      MDU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, c_FAST_LAT);
        run_op("div_ovf",      MDU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, c_FAST_LAT);
        run_op("mulhu_max",    MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, c_MUL_LAT);
        run_op("mul_max",      MDU_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, c_MUL_LAT);
        run_op("mulhsu_m1_2",  MDU_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, c_MUL_LAT);
        run_op("mul_small",    MDU_MUL,    32'h1234_5678, 32'h0000_0009, 32'hA3D7_0A38, c_MUL_LAT);
        run_op("mulh_minsq",   MDU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, c_MUL_LAT);
        run_op("div_100_m7",   MDU_DIV,    32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, c_DIV_LAT);
        run_op("rem_100_m7",   MDU_REM,    32'd100,       32'hFFFF_FFF9, 32'h0000_0002, c_DIV_LAT);

        // Kill a DIV in flight at cycle 10.
        dones = 0;
        @(negedge clk);
        bus.mdu_req_i    = 1'b1;
        bus.mdu_op_i     = MDU_DIV;
        bus.mdu_port_a_i = 32'd100;
        bus.mdu_port_b_i = 32'd7;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (bus.mdu_done_o) dones++;
            bus.mdu_req_i = 1'b0;
            if (cyc == 10) bus.mdu_kill_i = 1'b1;
        end
        @(negedge clk);
        check("kill_stall_c11", 32'(bus.mdu_stall_req_o), 32'd0);
        bus.mdu_kill_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.mdu_done_o) dones++;
        end
        check("kill_no_done", 32'(dones), 32'd0);
        check("kill_result_held", bus.mdu_result_o, last_result);

        run_op("divu_after_kill", MDU_DIVU, 32'd100, 32'd7, 32'd14, c_DIV_LAT);

        // Reset in cycle 20 of a MUL.
        dones = 0;
        @(negedge clk);
        bus.mdu_req_i    = 1'b1;
        bus.mdu_op_i     = MDU_MUL;
        bus.mdu_port_a_i = 32'h0000_1234;
        bus.mdu_port_b_i = 32'h0000_5678;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            bus.mdu_req_i = 1'b0;
            if (cyc == 20) rst = 1'b1;
        end
        @(negedge clk);
        check("rst_stall",  32'(bus.mdu_stall_req_o), 32'd0);
        check("rst_result", bus.mdu_result_o,         32'd0);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.mdu_done_o) dones++;
        end
        check("rst_no_done",      32'(dones),        32'd0);
        check("rst_result_after", bus.mdu_result_o,  32'd0);
        check("sb_drained",       32'(sb_q.size()),  32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
